clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
Front-panel controller for the digital clock. It turns three raw push-buttons (mode, up, down) into the set-mode sequencing signals for the hour, minute and second counter chains:
- per-field set enables;
- single-cycle up/down step pulses, with hold-to-repeat;
- a run gate for the 1 Hz tick;
- a seconds-clear pulse;
- a blink strobe for the display.
It sits between the button pads and the counter chains, and is the only source of set_ena/up/down for them.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each button synchronizer (minimum 2)
HOLD_CYCLES, 25_000_000, clk cycles a step button must be held before auto-repeat starts
REPEAT_CYCLES, 5_000_000, clk cycles between auto-repeat pulses
TIMEOUT_TICKS, 30, tick_1hz pulses with no button activity before a set state falls back to RUN
BLINK_TICKS, 1, tick_1hz pulses per blink phase

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
tick_1hz  input  1  one-cycle pulse per second from the prescaler
btn_mode  input  1  raw mode button, active-high, debounced externally, asynchronous to clk
btn_up  input  1  raw up button, same properties as btn_mode
btn_down  input  1  raw down button, same properties as btn_mode
run_ena  output  1  high only in RUN; gates tick_1hz into the seconds chain
hour_set_ena  output  1  high only in SET_HOUR
min_set_ena  output  1  high only in SET_MIN
up_pulse  output  1  one-cycle increment strobe to the enabled field
down_pulse  output  1  one-cycle decrement strobe to the enabled field
sec_clear  output  1  one-cycle pulse that zeroes the seconds chain
blink  output  1  display blank phase for the field being set; 0 in RUN
mode_state  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN

Behaviour:
Reset:
- rst asserted: state=RUN, all synchronizers, counters and edge registers cleared.
- Outputs during and after reset: run_ena=1, every other output 0.
- rst asserted mid-set discards any pending repeat or timeout.

Input conditioning:
- Each button passes through SYNC_STAGES flip-flops, then a rising-edge detector.
- Latency from a raw button edge to its response is SYNC_STAGES+1 cycles.

FSM, on the mode rising edge:
- RUN -> SET_HOUR -> SET_MIN -> RUN.
- On the SET_MIN -> RUN transition, sec_clear is pulsed for exactly one cycle, in the same cycle the registered state becomes RUN.

Timeout:
- A counter in the set states counts tick_1hz pulses.
- Any button rising edge or auto-repeat pulse clears it.
- When it reaches TIMEOUT_TICKS, state goes to RUN with no sec_clear.
- A mode edge in the same cycle as the timeout takes priority and performs the normal transition.

Stepping (set states only):
- In RUN, up/down edges are ignored and up_pulse/down_pulse stay 0.
- A rising edge on up gives one up_pulse the following cycle; down behaves the same way.
- Synchronized up and down both high: no pulses, and the repeat counter is held cleared.
- Auto-repeat:
  - while one step button stays high, a hold counter runs;
  - at HOLD_CYCLES, one pulse is emitted, then one every REPEAT_CYCLES;
  - releasing the button clears the counter immediately;
  - a mode edge or timeout cancels the repeat;
  - after a state change, the button must be released and pressed again before further pulses are emitted.

Blink:
- In set states, blink toggles every BLINK_TICKS tick_1hz pulses.
- blink is forced to 0 in RUN and on every state entry.

Other rules:
- Exactly one of run_ena, hour_set_ena and min_set_ena is high at any time; all three are registered outputs.
- Counter widths are $clog2 of the parameter value plus 1, with no wrap before the compare.

Decomposition:
Shared package clock_pkg holds:
- state encodings ST_RUN=2'd0, ST_SET_HOUR=2'd1, ST_SET_MIN=2'd2 (2'd3 is illegal and recovers to RUN);
- default timing constants, shared with the prescaler and display blocks.

One sub-module, button_conditioner (synchronizer, edge detect and hold/repeat counter), instantiated twice for up/down. The mode button uses its synchronizer and edge output only.

Test Plan:
1. Reset, then a mode press -> mode_state=1, hour_set_ena=1, run_ena=0, at SYNC_STAGES+1 cycles after the press.
2. HOLD_CYCLES=8, REPEAT_CYCLES=4, SET_MIN, up held 20 cycles -> pulses at press+3, +11, +15, +19; none after release.
3. Three mode presses -> RUN -> SET_HOUR -> SET_MIN -> RUN; sec_clear is one cycle high on the final transition; run_ena returns to 1.
4. TIMEOUT_TICKS=3, SET_HOUR with no buttons, 3 ticks -> RUN, sec_clear stays 0. Repeat with an up press after tick 2 -> remains in SET_HOUR until 3 further ticks.
5. up and down pressed on the same cycle in SET_MIN -> no up_pulse and no down_pulse. up pressed in RUN -> no pulse.
6. rst asserted asynchronously mid auto-repeat in SET_HOUR -> outputs take their reset values immediately. After release, up still held -> no pulses until mode is pressed and up is re-pressed.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock front panel: set-mode state encoding and
// default timing constants used by the controller, prescaler and display.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_BAD      = 2'd3
  } mode_state_t;

  localparam int DEF_CLK_HZ        = 50_000_000;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_HOLD_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;
  localparam int DEF_TIMEOUT_TICKS = 30;
  localparam int DEF_BLINK_TICKS   = 1;

  // One spare bit so a counter can hold its terminal value without wrapping.
  function automatic int cnt_width(input int value);
    return $clog2(value) + 1;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Step-button front end: synchronizer, rising-edge detect and the
// hold-to-repeat counter that produces auto-repeat strobes.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic hold_clr,
  input  logic lock,
  output logic level,
  output logic rise,
  output logic rpt
);

  localparam int CW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;
  logic                   locked;
  logic                   repeating;
  logic [CW-1:0]          hold_cnt;
  logic                   cnt_clr;
  logic                   hit;

  assign level   = sync_p[SYNC_STAGES-1];
  assign rise    = level & ~prev_p;
  // A press that survived a state change stays locked until released.
  assign cnt_clr = ~level | hold_clr | locked | lock;
  assign hit     = repeating ? (hold_cnt == REPEAT_LAST) : (hold_cnt == HOLD_LAST);
  assign rpt     = ~cnt_clr & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p    <= '0;
      prev_p    <= 1'b0;
      locked    <= 1'b0;
      repeating <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], btn};
      prev_p <= level;
      if (!level) begin
        locked <= 1'b0;
      end else if (lock) begin
        locked <= 1'b1;
      end
      if (cnt_clr) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (hit) begin
        hold_cnt  <= CW'(1);
        repeating <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel set-mode controller: turns mode/up/down buttons into field set
// enables, step pulses, the seconds clear and the display blink strobe.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int BLINK_TICKS   = DEF_BLINK_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       run_ena,
  output logic       hour_set_ena,
  output logic       min_set_ena,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       sec_clear,
  output logic       blink,
  output logic [1:0] mode_state
);

  localparam int TW = cnt_width(TIMEOUT_TICKS);
  localparam int BW = cnt_width(BLINK_TICKS);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);

  mode_state_t            state;
  mode_state_t            nxt;
  logic [SYNC_STAGES-1:0] mode_sync_p;
  logic                   mode_prev_p;
  logic                   mode_rise;
  logic                   up_lvl, up_rise, up_rpt;
  logic                   dn_lvl, dn_rise, dn_rpt;
  logic                   in_set, both, hold_clr, state_chg, timeout, activity;
  logic                   sec_clr_nxt, up_step, dn_step;
  logic [TW-1:0]          to_cnt;
  logic [BW-1:0]          blink_cnt;

  button_conditioner #(
    .SYNC_STAGES  (SYNC_STAGES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_up (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_up),
    .hold_clr(hold_clr),
    .lock    (state_chg),
    .level   (up_lvl),
    .rise    (up_rise),
    .rpt     (up_rpt)
  );

  button_conditioner #(
    .SYNC_STAGES  (SYNC_STAGES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_dn (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_down),
    .hold_clr(hold_clr),
    .lock    (state_chg),
    .level   (dn_lvl),
    .rise    (dn_rise),
    .rpt     (dn_rpt)
  );

  assign mode_rise  = mode_sync_p[SYNC_STAGES-1] & ~mode_prev_p;
  assign in_set     = (state == ST_SET_HOUR) || (state == ST_SET_MIN);
  assign both       = up_lvl & dn_lvl;
  assign hold_clr   = both | ~in_set;
  assign timeout    = in_set && (to_cnt == TIMEOUT_LAST);
  assign activity   = mode_rise | up_rise | dn_rise | up_rpt | dn_rpt;
  assign state_chg  = (nxt != state);
  assign up_step    = in_set & ~state_chg & ~both & (up_rise | up_rpt);
  assign dn_step    = in_set & ~state_chg & ~both & (dn_rise | dn_rpt);
  assign mode_state = state;

  // Mode edge outranks a timeout landing in the same cycle.
  always_comb begin
    nxt         = state;
    sec_clr_nxt = 1'b0;
    if (mode_rise) begin
      case (state)
        ST_RUN:      nxt = ST_SET_HOUR;
        ST_SET_HOUR: nxt = ST_SET_MIN;
        ST_SET_MIN: begin
          nxt         = ST_RUN;
          sec_clr_nxt = 1'b1;
        end
        default:     nxt = ST_RUN;
      endcase
    end else if (timeout || !in_set) begin
      nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      mode_sync_p  <= '0;
      mode_prev_p  <= 1'b0;
      run_ena      <= 1'b1;
      hour_set_ena <= 1'b0;
      min_set_ena  <= 1'b0;
      up_pulse     <= 1'b0;
      down_pulse   <= 1'b0;
      sec_clear    <= 1'b0;
      blink        <= 1'b0;
      to_cnt       <= '0;
      blink_cnt    <= '0;
    end else begin
      mode_sync_p  <= {mode_sync_p[SYNC_STAGES-2:0], btn_mode};
      mode_prev_p  <= mode_sync_p[SYNC_STAGES-1];
      state        <= nxt;
      run_ena      <= (nxt == ST_RUN);
      hour_set_ena <= (nxt == ST_SET_HOUR);
      min_set_ena  <= (nxt == ST_SET_MIN);
      up_pulse     <= up_step;
      down_pulse   <= dn_step;
      sec_clear    <= sec_clr_nxt;
      if (state_chg || !in_set || activity) begin
        to_cnt <= '0;
      end else if (tick_1hz) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state_chg || !in_set) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (tick_1hz) begin
        if (blink_cnt == BLINK_LAST) begin
          blink     <= ~blink;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller: a behavioural model predicts every
// output cycle, a monitor compares; directed cases cover the key timing points.
module tb_clock_set_controller;

  localparam int SYNC    = 2;
  localparam int HOLD    = 8;
  localparam int REPEAT  = 4;
  localparam int TIMEOUT = 3;
  localparam int BLINK   = 2;
  localparam logic [8:0] RST_VEC = 9'b00_1_0_0_0_0_0_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_1hz, btn_mode, btn_up, btn_down;
  logic run_ena, hour_set_ena, min_set_ena, up_pulse, down_pulse, sec_clear, blink;
  logic [1:0] mode_state;

  int checks = 0;
  int errors = 0;
  int up_cnt = 0, dn_cnt = 0, sc_cnt = 0;

  logic [8:0] exp_q[$];
  logic [2:0] iq[$];

  // reference model state (owned by the model process only)
  int m_state, seg_u, seg_d, idle, bticks;
  bit pm, pu, pd, armed_u, armed_d;
  bit lm, lu, ld, rm, ru, rd, ins, both, tmo, chg, sc, vu, vd, rpu, rpd, upp, dnp, bl;
  int ns;
  logic [2:0] smp;

  always #5 clk = ~clk;

  clock_set_controller #(
    .SYNC_STAGES  (SYNC),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REPEAT),
    .TIMEOUT_TICKS(TIMEOUT),
    .BLINK_TICKS  (BLINK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .run_ena     (run_ena),
    .hour_set_ena(hour_set_ena),
    .min_set_ena (min_set_ena),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .sec_clear   (sec_clear),
    .blink       (blink),
    .mode_state  (mode_state)
  );

  function automatic logic [8:0] out_vec();
    return {mode_state, run_ena, hour_set_ena, min_set_ena, up_pulse, down_pulse, sec_clear, blink};
  endfunction

  function automatic bit is_repeat(input int seg);
    return (seg >= HOLD) && (((seg - HOLD) % REPEAT) == 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc(4);
    btn_mode = 1'b0;
    cyc(4);
  endtask

  task automatic give_tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    cyc(3);
  endtask

  // Reference model: predicts the outputs that appear after each clock edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = 0; seg_u = 0; seg_d = 0; idle = 0; bticks = 0;
      pm = 0; pu = 0; pd = 0; armed_u = 0; armed_d = 0; bl = 0;
      iq.delete();
      exp_q.delete();
      exp_q.push_back(RST_VEC);
    end else begin
      iq.push_front({btn_mode, btn_up, btn_down});
      if (iq.size() > SYNC + 1) void'(iq.pop_back());
      smp = (iq.size() > SYNC) ? iq[SYNC] : 3'b000;
      lm = smp[2]; lu = smp[1]; ld = smp[0];
      rm = lm & ~pm; ru = lu & ~pu; rd = ld & ~pd;
      ins  = (m_state != 0);
      both = lu & ld;
      tmo  = ins && (idle == TIMEOUT);
      ns = m_state; sc = 0;
      if (rm) begin
        ns = (m_state + 1) % 3;
        sc = (m_state == 2);
      end else if (tmo) begin
        ns = 0;
      end
      chg = (ns != m_state);
      vu  = ins && !chg && lu && !ld && (armed_u || ru);
      vd  = ins && !chg && ld && !lu && (armed_d || rd);
      rpu = vu && is_repeat(seg_u);
      rpd = vd && is_repeat(seg_d);
      upp = ins && !chg && !both && (ru || rpu);
      dnp = ins && !chg && !both && (rd || rpd);
      if (!lu || chg) armed_u = 0; else if (ru && ins) armed_u = 1;
      if (!ld || chg) armed_d = 0; else if (rd && ins) armed_d = 1;
      seg_u = vu ? seg_u + 1 : 0;
      seg_d = vd ? seg_d + 1 : 0;
      if (chg || !ins || rm || ru || rd || rpu || rpd) idle = 0;
      else if (tick_1hz) idle++;
      if (chg || ns == 0) bticks = 0;
      else if (tick_1hz) bticks++;
      bl = ((bticks / BLINK) % 2) == 1;
      m_state = ns; pm = lm; pu = lu; pd = ld;
      exp_q.push_back({ns[1:0], ns == 0, ns == 1, ns == 2, upp, dnp, sc, bl});
    end
  end

  // Monitor: pops one prediction per cycle and compares it with the DUT.
  initial forever begin
    logic [8:0] e, a;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = out_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs: got %b, expected %b (t=%0t)", a, e, $time);
      end
    end
    if (up_pulse === 1'b1) up_cnt++;
    if (down_pulse === 1'b1) dn_cnt++;
    if (sec_clear === 1'b1) sc_cnt++;
  end

  initial begin
    int pulses[$];
    int exp_off[4] = '{3, 11, 15, 19};
    int u0, d0, s0;
    btn_mode = 0; btn_up = 0; btn_down = 0; tick_1hz = 0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("reset_outputs", int'(out_vec()), int'(RST_VEC));

    // mode press reaches the state register SYNC+1 cycles later
    btn_mode = 1'b1;
    cyc(2);
    check("mode_latency_early", mode_state, 0);
    cyc(1);
    check("mode_state_hour", mode_state, 1);
    check("hour_set_ena", hour_set_ena, 1);
    check("run_ena_off", run_ena, 0);
    btn_mode = 1'b0;
    cyc(4);

    // hold-to-repeat in SET_MIN
    press_mode();
    check("mode_state_min", mode_state, 2);
    btn_up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (up_pulse) pulses.push_back(i);
      if (i == 20) btn_up = 1'b0;
    end
    check("repeat_pulse_count", pulses.size(), 4);
    for (int i = 0; i < 4; i++)
      check("repeat_pulse_offset", (i < pulses.size()) ? pulses[i] : -1, exp_off[i]);

    // SET_MIN -> RUN pulses sec_clear once
    s0 = sc_cnt;
    btn_mode = 1'b1;
    cyc(3);
    check("back_to_run", mode_state, 0);
    check("run_ena_back", run_ena, 1);
    check("sec_clear_high", sec_clear, 1);
    cyc(1);
    check("sec_clear_one_cycle", sec_clear, 0);
    btn_mode = 1'b0;
    cyc(4);
    check("sec_clear_count", sc_cnt - s0, 1);

    // timeout without activity, then with an up press restarting it
    s0 = sc_cnt;
    press_mode();
    repeat (3) give_tick();
    check("timeout_to_run", mode_state, 0);
    check("timeout_no_sec_clear", sc_cnt - s0, 0);
    press_mode();
    repeat (2) give_tick();
    btn_up = 1'b1; cyc(4); btn_up = 1'b0; cyc(4);
    repeat (2) give_tick();
    check("timeout_restarted", mode_state, 1);
    give_tick();
    check("timeout_after_press", mode_state, 0);

    // simultaneous up+down in SET_MIN, and up in RUN
    press_mode();
    press_mode();
    check("both_state_min", mode_state, 2);
    u0 = up_cnt; d0 = dn_cnt;
    btn_up = 1'b1; btn_down = 1'b1;
    cyc(20);
    btn_up = 1'b0; btn_down = 1'b0;
    cyc(4);
    check("both_no_up", up_cnt - u0, 0);
    check("both_no_down", dn_cnt - d0, 0);
    press_mode();
    u0 = up_cnt;
    btn_up = 1'b1; cyc(15); btn_up = 1'b0; cyc(4);
    check("run_ignores_up", up_cnt - u0, 0);

    // async reset during auto-repeat, then the button must be re-pressed
    press_mode();
    u0 = up_cnt;
    btn_up = 1'b1;
    cyc(14);
    check("repeat_before_reset", up_cnt - u0, 2);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", int'(out_vec()), int'(RST_VEC));
    cyc(2);
    rst = 1'b0;
    u0 = up_cnt;
    cyc(20);
    check("post_reset_state", mode_state, 0);
    press_mode();
    cyc(20);
    check("locked_after_change", up_cnt - u0, 0);
    btn_up = 1'b0;
    cyc(4);
    btn_up = 1'b1;
    cyc(3);
    check("repress_pulse", up_pulse, 1);
    cyc(2);
    btn_up = 1'b0;
    cyc(4);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 4000; i++) begin
      tick_1hz = ($urandom_range(0, 14) == 0);
      if (btn_mode) btn_mode = ($urandom_range(0, 3) != 0);
      else          btn_mode = ($urandom_range(0, 59) == 0);
      if (btn_up)   btn_up   = ($urandom_range(0, 11) != 0);
      else          btn_up   = ($urandom_range(0, 19) == 0);
      if (btn_down) btn_down = ($urandom_range(0, 11) != 0);
      else          btn_down = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end else begin
        cyc(1);
      end
    end
    tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
